// File: rtl/riscv_multicycle.sv
// Multicycle RV32I-subset core (lw, sw, add/sub/and/or/slt, addi/andi/ori/slti, beq, jal).
// Fetch and data accesses share one memory port with a req/ready handshake.
module riscv_multicycle #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          NREGS    = 32
) (
  input  logic        clk,
  input  logic        reset,
  output logic        MemReq,
  output logic        MemWrite,
  output logic [31:0] Adr,
  output logic [31:0] WriteData,
  input  logic        MemReady,
  input  logic [31:0] ReadData,
  output logic [31:0] PC,
  output logic        InstrRetired,
  output logic        Illegal
);

  localparam int RAW = $clog2(NREGS);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL, S_HALT
  } state_e;

  state_e      state_q, state_d, dec_state;
  logic [31:0] pc_q, old_pc_q, ir_q, a_q, b_q, alu_out_q, data_q;
  logic [31:0] rf_q [NREGS];

  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm_i, imm_s, imm_b, imm_j;
  logic [31:0] src_b, alu_res, rf_wd;
  logic        rf_we, alu_f3_ok, mem_req, mem_wr, retire;

  assign opcode = ir_q[6:0];
  assign rd     = ir_q[11:7];
  assign funct3 = ir_q[14:12];
  assign rs1    = ir_q[19:15];
  assign rs2    = ir_q[24:20];
  assign funct7 = ir_q[31:25];

  assign imm_i = {{20{ir_q[31]}}, ir_q[31:20]};
  assign imm_s = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
  assign imm_b = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
  assign imm_j = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};

  // RV32E builds must reject any register field that names x16..x31.
  function automatic logic reg_ok(input logic [4:0] r);
    return int'(r) < NREGS;
  endfunction

  assign alu_f3_ok = funct3 inside {3'b000, 3'b010, 3'b110, 3'b111};

  always_comb begin
    // NOTE: every signal assigned in always_comb gets a default first, so no path infers a latch.
    dec_state = S_HALT;
    case (opcode)
      OP_LOAD:  if (funct3 == 3'b010 && reg_ok(rs1) && reg_ok(rd)) dec_state = S_MEMADR;
      OP_STORE: if (funct3 == 3'b010 && reg_ok(rs1) && reg_ok(rs2)) dec_state = S_MEMADR;
      OP_R:     if (alu_f3_ok && (funct7 == 7'b0000000 || (funct7 == 7'b0100000 && funct3 == 3'b000))
                    && reg_ok(rs1) && reg_ok(rs2) && reg_ok(rd)) dec_state = S_EXECR;
      OP_I:     if (alu_f3_ok && reg_ok(rs1) && reg_ok(rd)) dec_state = S_EXECI;
      OP_BR:    if (funct3 == 3'b000 && reg_ok(rs1) && reg_ok(rs2)) dec_state = S_BEQ;
      OP_JAL:   if (reg_ok(rd)) dec_state = S_JAL;
      default:  dec_state = S_HALT;
    endcase
  end

  assign src_b = (state_q == S_EXECI) ? imm_i : b_q;

  always_comb begin
    alu_res = '0;
    case (funct3)
      3'b000:  alu_res = (state_q == S_EXECR && funct7[5]) ? a_q - src_b : a_q + src_b;
      3'b010:  alu_res = {31'b0, $signed(a_q) < $signed(src_b)};
      3'b110:  alu_res = a_q | src_b;
      3'b111:  alu_res = a_q & src_b;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    mem_req = 1'b0;
    mem_wr  = 1'b0;
    retire  = 1'b0;
    case (state_q)
      S_FETCH:  begin mem_req = 1'b1; if (MemReady) state_d = S_DECODE; end
      S_DECODE: state_d = dec_state;
      S_MEMADR: state_d = (opcode == OP_STORE) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  begin mem_req = 1'b1; if (MemReady) state_d = S_MEMWB; end
      S_MEMWR:  begin
        mem_req = 1'b1;
        mem_wr  = 1'b1;
        if (MemReady) begin retire = 1'b1; state_d = S_FETCH; end
      end
      S_EXECR, S_EXECI: state_d = S_ALUWB;
      S_MEMWB, S_ALUWB, S_BEQ, S_JAL: begin retire = 1'b1; state_d = S_FETCH; end
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_HALT;
    endcase
  end

  // Reset gates the handshake combinationally so a pending access drops without a clock edge.
  assign MemReq       = mem_req & ~reset;
  assign MemWrite     = mem_wr  & ~reset;
  assign InstrRetired = retire  & ~reset;
  assign Illegal      = (state_q == S_HALT);
  assign Adr          = (state_q == S_FETCH) ? pc_q : alu_out_q;
  assign WriteData    = b_q;
  assign PC           = pc_q;

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q      <= RESET_PC;
      old_pc_q  <= RESET_PC;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      alu_out_q <= '0;
      data_q    <= '0;
    end else begin
      case (state_q)
        S_FETCH: if (MemReady) begin
          ir_q     <= ReadData;
          old_pc_q <= pc_q;
          pc_q     <= pc_q + 32'd4;
        end
        S_DECODE: begin
          a_q       <= rf_q[rs1[RAW-1:0]];
          b_q       <= rf_q[rs2[RAW-1:0]];
          alu_out_q <= old_pc_q + imm_b;
        end
        S_MEMADR:         alu_out_q <= a_q + ((opcode == OP_STORE) ? imm_s : imm_i);
        S_MEMRD:          if (MemReady) data_q <= ReadData;
        S_EXECR, S_EXECI: alu_out_q <= alu_res;
        S_BEQ:            if (a_q == b_q) pc_q <= alu_out_q;
        S_JAL:            pc_q <= old_pc_q + imm_j;
        default: ;
      endcase
    end
  end

  assign rf_we = (state_q inside {S_MEMWB, S_ALUWB, S_JAL}) && (rd != 5'd0);

  always_comb begin
    rf_wd = alu_out_q;
    if (state_q == S_MEMWB)  rf_wd = data_q;
    else if (state_q == S_JAL) rf_wd = old_pc_q + 32'd4;
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: the register file is reset explicitly because software may read any register before writing it.
    if (reset) begin
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else if (rf_we) begin
      rf_q[rd[RAW-1:0]] <= rf_wd;
    end
  end

endmodule
